lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the RV32I data memory.
- Accepts load/store requests from the execute stage over a valid/ready handshake and checks width encoding, alignment and address range.
- Drives the data-memory port (addr, mem_width, write_enable) for exactly one cycle per legal request, captures the read word, and returns a registered response to writeback.
- Every register has a defined reset value; nothing powers up unknown.

Parameters:
- DEPTH_WORDS, 200, words in data memory; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- PROT_BASE, 32'h0000_0060, first byte of the lockable region (used only with the optional feature).
- PROT_BYTES, 32'h10, size in bytes of the lockable region.

Ports:
- clk  in  1  single clock, rising-edge registers.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_rd  in  5  destination register tag.
- mem_en  out  1  memory access active this cycle.
- mem_we  out  1  to data memory write_enable.
- mem_width  out  3  to data memory mem_width.
- mem_addr  out  32  to data memory addr.
- mem_wdata  out  32  to data memory write_data.
- mem_rdata  in  32  from data memory read_data (combinational).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  writeback accepts response.
- rsp_rdata  out  32  load result; 0 for stores and faults.
- rsp_rd  out  5  echoed tag.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range / illegal width, 11 locked-region write.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- FSM states: IDLE, ACCESS, RESP. Reset forces IDLE.
- Reset values: all outputs 0 except req_ready=1. Request holding registers clear to 0.
- IDLE: req_ready=1. On req_valid, latch the request and compute the fault code.
  - fault==00 -> ACCESS.
  - Otherwise -> RESP directly; memory is never touched.
- Fault priority, highest first:
  - Illegal width: funct3 011/110/111; for stores, any funct3 other than 000/001/010.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Out of range: addr >= 4*DEPTH_WORDS, compared as a 32-bit unsigned value.
  - Locked region (optional feature only).
- ACCESS (exactly one cycle):
  - mem_en=1; mem_addr, mem_width, mem_wdata are driven from the latched request.
  - mem_we = latched_we & (state==ACCESS) & ~reset. This is combinational, so a reset in this cycle suppresses the negedge write in memory.
  - For loads, mem_rdata is captured into rsp_rdata on the rising edge. -> RESP.
- Outside ACCESS: mem_en, mem_we, mem_addr, mem_width, mem_wdata are all 0.
- RESP: rsp_valid=1; rsp_rdata, rsp_rd, rsp_fault are stable until rsp_ready. On rsp_ready -> IDLE. A new request is not accepted in the same cycle.
- Latency:
  - Legal access: request accepted at edge 0, memory access in cycle 1, rsp_valid in cycle 2.
  - Faulted request: rsp_valid in cycle 1.
- Throughput: one request per 3 cycles at best, no pipelining.
- Reset in any state returns to IDLE on that edge and drops any pending response.

Optional Feature:
- Macro: LSU_REGION_LOCK_EN.
- Defined:
  - Adds a lock bit that resets to 1 (locked).
  - Extra ports: unlock_req in 1, lock_req in 1. lock_req wins if both are high.
  - While locked, a store to [PROT_BASE, PROT_BASE+PROT_BYTES) faults with 11 and mem_we stays 0. Loads are unaffected.
  - Lock state is exported on lock_state out 1.
- Undefined: no lock bit, no extra ports, fault code 11 is never produced.

Decomposition:
- Shared package lsu_pkg holds:
  - width codes (SIGNED_B etc.);
  - state enum lsu_state_t;
  - fault enum lsu_fault_t;
  - request struct lsu_req_t.
- One sub-module, lsu_fault_check: combinational fault classifier taking we, funct3, addr and lock and returning lsu_fault_t.

Test Plan:
- Reset asserted 3 cycles, then released -> req_ready=1, rsp_valid=0, mem_we=0; with the feature enabled, lock_state=1.
- Store W, addr 0x10, data 0xDEADBEEF, then load W at 0x10 -> store response fault 00 in cycle 2; load rsp_rdata=0xDEADBEEF.
- Load H at addr 0x13 -> rsp_fault=01 in cycle 1; mem_en never asserted.
- Load W at addr 0x320 (=4*200) -> fault 10; load at 0x31C -> ok.
- Store with mem_we high in ACCESS and reset asserted that cycle -> mem_we=0 immediately, FSM in IDLE next edge, memory word unchanged.
- LSU_REGION_LOCK_EN: store to 0x64 after reset -> fault 11, no write. Pulse unlock_req, repeat the store -> fault 00 and the memory word is updated.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store control stage: width codes, FSM states,
// fault codes and the latched request record.
package lsu_pkg;

   localparam logic [2:0] SIGNED_B   = 3'b000;
   localparam logic [2:0] SIGNED_H   = 3'b001;
   localparam logic [2:0] WORD       = 3'b010;
   localparam logic [2:0] UNSIGNED_B = 3'b100;
   localparam logic [2:0] UNSIGNED_H = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      FLT_OK       = 2'b00,
      FLT_MISALIGN = 2'b01,
      FLT_RANGE    = 2'b10,
      FLT_LOCKED   = 2'b11
   } lsu_fault_t;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } lsu_req_t;

endpackage

// File: rtl/lsu_fault_check.sv
// Combinational request classifier: width legality, alignment, address range
// and locked-region stores, reported by priority as one lsu_fault_t.
module lsu_fault_check
   import lsu_pkg::*;
#(
   parameter int          DEPTH_WORDS = 200,
   parameter logic [31:0] PROT_BASE   = 32'h0000_0060,
   parameter logic [31:0] PROT_BYTES  = 32'h10
) (
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic        lock,
   output lsu_fault_t  fault
);

   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
   localparam logic [31:0] PROT_END   = PROT_BASE + PROT_BYTES;

   logic width_ok;
   logic misaligned;
   logic in_range;
   logic in_prot;

   always_comb begin
      width_ok   = 1'b0;
      misaligned = 1'b0;
      case (funct3)
         SIGNED_B, SIGNED_H, WORD: width_ok = 1'b1;
         UNSIGNED_B, UNSIGNED_H:   width_ok = ~we;   // unsigned codes are load-only
         default:                  width_ok = 1'b0;
      endcase
      case (funct3)
         SIGNED_H, UNSIGNED_H: misaligned = addr[0];
         WORD:                 misaligned = |addr[1:0];
         default:              misaligned = 1'b0;
      endcase
      in_range = addr < ADDR_LIMIT;
      in_prot  = (addr >= PROT_BASE) && (addr < PROT_END);

      fault = FLT_OK;
      if (!width_ok)                 fault = FLT_RANGE;
      else if (misaligned)           fault = FLT_MISALIGN;
      else if (!in_range)            fault = FLT_RANGE;
      else if (we && lock && in_prot) fault = FLT_LOCKED;
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the RV32I data memory: IDLE/ACCESS/RESP
// handshake FSM. Optional store lock on a protected region: LSU_REGION_LOCK_EN.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int          DEPTH_WORDS = 200,
   parameter logic [31:0] PROT_BASE   = 32'h0000_0060,
   parameter logic [31:0] PROT_BYTES  = 32'h10
) (
   input  logic        clk,
   input  logic        reset,
`ifdef LSU_REGION_LOCK_EN
   input  logic        unlock_req,
   input  logic        lock_req,
   output logic        lock_state,
`endif
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_en,
   output logic        mem_we,
   output logic [2:0]  mem_width,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [4:0]  rsp_rd,
   output logic [1:0]  rsp_fault
);

   lsu_state_t state, state_nxt;
   lsu_req_t   req_q;
   lsu_fault_t fault_q, fault_in;
   logic [31:0] rdata_q;
   logic        lock;

`ifdef LSU_REGION_LOCK_EN
   logic lock_q;

   // lock_req has priority so a simultaneous request leaves the region locked
   always_ff @(posedge clk) begin
      if (reset)           lock_q <= 1'b1;
      else if (lock_req)   lock_q <= 1'b1;
      else if (unlock_req) lock_q <= 1'b0;
   end

   assign lock       = lock_q;
   assign lock_state = lock_q;
`else
   assign lock = 1'b0;
`endif

   lsu_fault_check #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .PROT_BASE   (PROT_BASE),
      .PROT_BYTES  (PROT_BYTES)
   ) u_fault_check (
      .we     (req_we),
      .funct3 (req_funct3),
      .addr   (req_addr),
      .lock   (lock),
      .fault  (fault_in)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         req_q   <= '0;
         fault_q <= FLT_OK;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_q   <= '{we: req_we, funct3: req_funct3, addr: req_addr,
                               wdata: req_wdata, rd: req_rd};
                  fault_q <= fault_in;
                  rdata_q <= '0;
               end
            end
            ST_ACCESS: begin
               if (!req_q.we) rdata_q <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_width = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_rd    = '0;
      rsp_fault = FLT_OK;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = (fault_in == FLT_OK) ? ST_ACCESS : ST_RESP;
         end
         ST_ACCESS: begin
            mem_en    = 1'b1;
            // reset gates the write combinationally so memory's negedge write is dropped
            mem_we    = req_q.we & ~reset;
            mem_width = req_q.funct3;
            mem_addr  = req_q.addr;
            mem_wdata = req_q.wdata;
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_rdata = rdata_q;
            rsp_rd    = req_q.rd;
            rsp_fault = fault_q;
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
